mp_lut_coeff_loader: RTL and testbench

Sequences coefficient writes into the MP LUT bank. It accepts a 32-bit stream of LUT entries (I in [31:16], Q in [15:0]) on the AXI clock domain. It generates the per-entry address, LUT number and write enable that drive the LUT write port (coeff_data/addr/num/en). It checks frame length, tracks which LUTs hold a complete table, and reports busy, done and error status to the host.

---
 rtl/mp_lut_coeff_loader.sv | 167 ++++++++++++++++
 tb/tb_mp_lut_coeff_loader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mp_lut_coeff_loader.sv
// Coefficient loader for the MP LUT bank: turns an AXI-Stream of I/Q entries into
// LUT write-port transactions, checking frame length and tracking complete tables.
module mp_lut_coeff_loader #(
  parameter int M           = 3,
  parameter int LUT_NUM     = M + 1,
  parameter int RESOLUTION  = 4096,
  parameter int COEFF_WIDTH = $clog2(RESOLUTION),
  parameter int NUM_W       = $clog2(M) + 1
) (
  input  logic                   AXI_clk_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic [NUM_W-1:0]       lut_sel_i,
  input  logic                   all_luts_i,
  input  logic [31:0]            s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  output logic [31:0]            coeff_data_o,
  output logic [COEFF_WIDTH-1:0] coeff_addr_o,
  output logic [NUM_W-1:0]       coeff_num_o,
  output logic                   coeff_en_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [LUT_NUM-1:0]     lut_loaded_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DRAIN = 2'd2} state_t;

  localparam logic [NUM_W-1:0]       LAST_LUT  = NUM_W'(M);
  localparam logic [COEFF_WIDTH-1:0] LAST_ADDR = COEFF_WIDTH'(RESOLUTION - 1);

  state_t                 state_q, state_d;
  logic [COEFF_WIDTH-1:0] cnt_q, cnt_d;
  logic [NUM_W-1:0]       cur_lut_q, cur_lut_d;
  logic                   all_luts_q, all_luts_d;
  logic                   tready_q, tready_d;
  logic [31:0]            data_q, data_d;
  logic [COEFF_WIDTH-1:0] addr_q, addr_d;
  logic [NUM_W-1:0]       num_q, num_d;
  logic                   en_q, en_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [LUT_NUM-1:0]     loaded_q, loaded_d;
  logic                   beat;
  logic                   illegal;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_lut_d  = cur_lut_q;
    all_luts_d = all_luts_q;
    data_d     = data_q;
    addr_d     = addr_q;
    num_d      = num_q;
    en_d       = 1'b0;
    done_d     = 1'b0;
    err_d      = err_q;
    loaded_d   = loaded_q;
    illegal    = 1'b0;
    beat       = s_axis_tvalid && tready_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (lut_sel_i > LAST_LUT) begin
            err_d   = 1'b1;
            illegal = 1'b1;
          end else begin
            err_d = 1'b0;
            for (int unsigned n = 0; n < LUT_NUM; n++) begin
              if ((n >= 32'(lut_sel_i)) && (all_luts_i || (n == 32'(lut_sel_i))))
                loaded_d[n] = 1'b0;
            end
            cur_lut_d  = lut_sel_i;
            cnt_d      = '0;
            all_luts_d = all_luts_i;
            state_d    = LOAD;
          end
        end
      end
      LOAD: begin
        if (beat) begin
          en_d   = 1'b1;
          data_d = s_axis_tdata;
          addr_d = cnt_q;
          num_d  = cur_lut_q;
          if (cnt_q != LAST_ADDR) begin
            if (s_axis_tlast) begin
              err_d   = 1'b1;
              state_d = IDLE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else if (s_axis_tlast) begin
            for (int unsigned n = 0; n < LUT_NUM; n++) begin
              if (n == 32'(cur_lut_q)) loaded_d[n] = 1'b1;
            end
            if (all_luts_q && (cur_lut_q < LAST_LUT)) begin
              cur_lut_d = cur_lut_q + 1'b1;
              cnt_d     = '0;
            end else begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end else begin
            err_d   = 1'b1;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (beat && s_axis_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Status outputs are registered, so they are derived from the next state.
    tready_d = (state_d != IDLE);
    busy_d   = (state_d != IDLE) || illegal;
  end

  always_ff @(posedge AXI_clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cur_lut_q  <= '0;
      all_luts_q <= 1'b0;
      tready_q   <= 1'b0;
      data_q     <= '0;
      addr_q     <= '0;
      num_q      <= '0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      loaded_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_lut_q  <= cur_lut_d;
      all_luts_q <= all_luts_d;
      tready_q   <= tready_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      num_q      <= num_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      loaded_q   <= loaded_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign coeff_data_o  = data_q;
  assign coeff_addr_o  = addr_q;
  assign coeff_num_o   = num_q;
  assign coeff_en_o    = en_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign lut_loaded_o  = loaded_q;

endmodule

// File: tb/tb_mp_lut_coeff_loader.sv
// Randomized bench for mp_lut_coeff_loader: a list-level model predicts every LUT
// write, completion mask and error flag from the beats sent.
module tb_mp_lut_coeff_loader;

  localparam int M  = 3;
  localparam int R  = 16;
  localparam int NW = 3;
  localparam int CW = 4;
  localparam int LN = 4;

  logic          clk = 1'b0;
  logic          reset_i, start_i, all_luts_i;
  logic [NW-1:0] lut_sel_i;
  logic [31:0]   s_axis_tdata;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [31:0]   coeff_data_o;
  logic [CW-1:0] coeff_addr_o;
  logic [NW-1:0] coeff_num_o;
  logic          coeff_en_o, busy_o, done_o, err_o;
  logic [LN-1:0] lut_loaded_o;

  always #5 clk = ~clk;

  mp_lut_coeff_loader #(.M(M), .RESOLUTION(R)) dut (
    .AXI_clk_i    (clk),
    .reset_i      (reset_i),
    .start_i      (start_i),
    .lut_sel_i    (lut_sel_i),
    .all_luts_i   (all_luts_i),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast (s_axis_tlast),
    .coeff_data_o (coeff_data_o),
    .coeff_addr_o (coeff_addr_o),
    .coeff_num_o  (coeff_num_o),
    .coeff_en_o   (coeff_en_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .lut_loaded_o (lut_loaded_o)
  );

  typedef struct {logic [31:0] data; int addr; int num; bit done; logic [LN-1:0] mask;} wr_t;
  typedef struct {logic [31:0] data; bit last;} beat_t;

  wr_t           exp_q[$];
  beat_t         beats[$];
  wr_t           mon_w;
  int            n_vec = 0;
  int            n_err = 0;
  int            done_seen = 0;
  int            d0;
  logic [LN-1:0] mask_m = '0;
  bit            err_m = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Predicts the writes one load produces from the beat list and the loader's rules.
  task automatic model_load(input int sel, input bit all);
    int  lut, addr;
    bit  drain, stop;
    wr_t w;
    if (sel > M) begin
      err_m = 1'b1;
      return;
    end
    err_m = 1'b0;
    for (int n = sel; n <= M; n++) if (all || n == sel) mask_m[n] = 1'b0;
    lut = sel; addr = 0; drain = 1'b0; stop = 1'b0;
    for (int i = 0; i < beats.size() && !stop; i++) begin
      if (drain) begin
        if (beats[i].last) stop = 1'b1;
      end else begin
        w.data = beats[i].data; w.addr = addr; w.num = lut; w.done = 1'b0;
        if (addr < R - 1) begin
          if (beats[i].last) begin err_m = 1'b1; stop = 1'b1; end
          else addr++;
        end else if (beats[i].last) begin
          mask_m[lut] = 1'b1;
          if (all && lut < M) begin lut++; addr = 0; end
          else begin w.done = 1'b1; stop = 1'b1; end
        end else begin
          err_m = 1'b1; drain = 1'b1;
        end
        w.mask = mask_m;
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic add_frame(input int len, input int last_at, input bit seq);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = seq ? (32'h0001_0000 + 32'(i)) : $urandom;
      b.last = (i == last_at);
      beats.push_back(b);
    end
  endtask

  task automatic do_start(input int sel, input bit all);
    start_i = 1'b1; lut_sel_i = 3'(sel); all_luts_i = all;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic send_beats(input bit gaps, input int start_at);
    int to;
    for (int i = 0; i < beats.size(); i++) begin
      if (gaps) while ($urandom_range(0, 3) == 0) begin s_axis_tvalid = 1'b0; @(negedge clk); end
      s_axis_tvalid = 1'b1; s_axis_tdata = beats[i].data; s_axis_tlast = beats[i].last;
      if (i == start_at) begin start_i = 1'b1; lut_sel_i = 3'd2; all_luts_i = 1'b0; end
      to = 0;
      while (!s_axis_tready && to < 100) begin @(negedge clk); to++; end
      if (to >= 100) begin check_eq("tready_timeout", s_axis_tready, 1); break; end
      @(negedge clk);
      start_i = 1'b0;
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task automatic finish_load(input string tag);
    repeat (3) @(negedge clk);
    check_eq({tag, "_pending"}, exp_q.size(), 0);
    check_eq({tag, "_err"}, err_o, err_m);
    check_eq({tag, "_loaded"}, lut_loaded_o, mask_m);
    check_eq({tag, "_busy"}, busy_o, 0);
    check_eq({tag, "_tready"}, s_axis_tready, 0);
  endtask

  always @(negedge clk) begin
    if (coeff_en_o) begin
      if (exp_q.size() == 0) check_eq("extra_write", coeff_en_o, 0);
      else begin
        mon_w = exp_q.pop_front();
        check_eq("wr_data", coeff_data_o, mon_w.data);
        check_eq("wr_addr", 32'(coeff_addr_o), mon_w.addr);
        check_eq("wr_num", 32'(coeff_num_o), mon_w.num);
        check_eq("wr_done", done_o, mon_w.done);
        check_eq("wr_loaded", lut_loaded_o, mon_w.mask);
      end
    end else if (done_o) check_eq("stray_done", done_o, 0);
    if (done_o) done_seen++;
  end

  initial begin
    reset_i = 1'b1; start_i = 1'b0; lut_sel_i = '0; all_luts_i = 1'b0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_en", coeff_en_o, 0);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_done", done_o, 0);
    check_eq("rst_err", err_o, 0);
    check_eq("rst_loaded", lut_loaded_o, 0);
    check_eq("rst_tready", s_axis_tready, 0);
    check_eq("rst_data", coeff_data_o, 0);
    reset_i = 1'b0;
    @(negedge clk);

    // Single LUT, sequential data
    beats.delete(); add_frame(16, 15, 1'b1); model_load(2, 1'b0);
    d0 = done_seen; do_start(2, 1'b0); send_beats(1'b0, -1); finish_load("single");
    check_eq("single_loaded_lit", lut_loaded_o, 4'b0100);
    check_eq("single_done_cnt", done_seen - d0, 1);

    // LUTs 1..3 back-to-back with tvalid gaps
    beats.delete(); for (int f = 0; f < 3; f++) add_frame(16, 15, 1'b0);
    model_load(1, 1'b1);
    d0 = done_seen; do_start(1, 1'b1); send_beats(1'b1, -1); finish_load("all");
    check_eq("all_loaded_lit", lut_loaded_o, 4'b1110);
    check_eq("all_done_cnt", done_seen - d0, 1);

    // Short frame
    beats.delete(); add_frame(10, 9, 1'b0); model_load(0, 1'b0);
    d0 = done_seen; do_start(0, 1'b0); send_beats(1'b1, -1); finish_load("short");
    check_eq("short_err_lit", err_o, 1);
    check_eq("short_done_cnt", done_seen - d0, 0);

    // Long frame: four beats drained
    beats.delete(); add_frame(20, 19, 1'b0); model_load(3, 1'b0);
    d0 = done_seen; do_start(3, 1'b0); send_beats(1'b1, -1); finish_load("long");
    check_eq("long_loaded_lit", lut_loaded_o, 4'b0110);
    check_eq("long_done_cnt", done_seen - d0, 0);

    // Next good start clears the sticky error
    beats.delete(); add_frame(16, 15, 1'b0); model_load(0, 1'b0);
    do_start(0, 1'b0);
    check_eq("clr_err", err_o, 0);
    check_eq("clr_busy", busy_o, 1);
    send_beats(1'b1, -1); finish_load("clr");

    // Illegal LUT select
    model_load(5, 1'b0);
    do_start(5, 1'b0);
    check_eq("ill_busy", busy_o, 1);
    check_eq("ill_err", err_o, 1);
    check_eq("ill_tready", s_axis_tready, 0);
    @(negedge clk);
    check_eq("ill_busy_fall", busy_o, 0);
    check_eq("ill_tready2", s_axis_tready, 0);
    check_eq("ill_loaded", lut_loaded_o, mask_m);

    // Reset after beat 7, extra start at beat 3 must be ignored
    beats.delete(); add_frame(8, -1, 1'b0); model_load(0, 1'b1);
    do_start(0, 1'b1); send_beats(1'b1, 3);
    reset_i = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_en", coeff_en_o, 0);
    check_eq("mid_rst_busy", busy_o, 0);
    check_eq("mid_rst_err", err_o, 0);
    check_eq("mid_rst_loaded", lut_loaded_o, 0);
    check_eq("mid_rst_tready", s_axis_tready, 0);
    check_eq("mid_rst_addr", 32'(coeff_addr_o), 0);
    check_eq("mid_rst_pending", exp_q.size(), 0);
    reset_i = 1'b0; mask_m = '0; err_m = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("post_rst_busy", busy_o, 0);
    check_eq("post_rst_en", coeff_en_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
